vga_timing_gen: RTL and testbench



---
 rtl/vga_pkg.sv | 37 +++
 rtl/sync_delay.sv | 35 +++
 rtl/vga_timing_gen.sv | 104 ++++++++++
 tb/tb_vga_timing_gen.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
`default_nettype none
// ==========================================================================
// vga_pkg : 640x480@60 raster constants and per-pixel phase encodings
// Rev 1.0
// ==========================================================================
package vga_pkg;

  typedef enum logic [1:0] {
    TEXT_FETCH     = 2'd0,
    GLYPH_FETCH    = 2'd1,
    SET_FOREGROUND = 2'd2,
    DRAW           = 2'd3
  } pixel_state_t;

  localparam int unsigned VGA_H_VISIBLE  = 640;
  localparam int unsigned VGA_H_FRONT    = 16;
  localparam int unsigned VGA_H_SYNC     = 96;
  localparam int unsigned VGA_H_BACK     = 48;
  localparam int unsigned VGA_V_VISIBLE  = 480;
  localparam int unsigned VGA_V_FRONT    = 10;
  localparam int unsigned VGA_V_SYNC     = 2;
  localparam int unsigned VGA_V_BACK     = 33;
  localparam int unsigned VGA_SYNC_DELAY = 3;

  localparam int unsigned VGA_H_TOTAL =
    VGA_H_VISIBLE + VGA_H_FRONT + VGA_H_SYNC + VGA_H_BACK;
  localparam int unsigned VGA_V_TOTAL =
    VGA_V_VISIBLE + VGA_V_FRONT + VGA_V_SYNC + VGA_V_BACK;

  function automatic logic in_span(input logic [9:0] val,
                                   input logic [9:0] lo,
                                   input logic [9:0] hi);
    return (val >= lo) && (val <= hi);
  endfunction

endpackage
`default_nettype wire

// File: rtl/sync_delay.sv
`default_nettype none
// ==========================================================================
// sync_delay : DEPTH-stage, 2-bit shift register preset to all ones
// Rev 1.0
// ==========================================================================
module sync_delay #(
  parameter int unsigned DEPTH = 3
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [1:0] d_i,
  output logic [1:0] q_o
);

  generate
    if (DEPTH == 0) begin : g_bypass
      assign q_o = d_i;
    end else begin : g_shift
      logic [1:0] stage_q [DEPTH];

      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
          for (int i = 0; i < int'(DEPTH); i++) stage_q[i] <= 2'b11;
        end else begin
          stage_q[0] <= d_i;
          for (int i = 1; i < int'(DEPTH); i++) stage_q[i] <= stage_q[i-1];
        end
      end

      assign q_o = stage_q[DEPTH-1];
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/vga_timing_gen.sv
`default_nettype none
// ==========================================================================
// vga_timing_gen : raster counters, pixel phase, visible enable, delayed syncs
// Rev 1.0
// ==========================================================================
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int unsigned H_VISIBLE  = VGA_H_VISIBLE,
  parameter int unsigned H_FRONT    = VGA_H_FRONT,
  parameter int unsigned H_SYNC     = VGA_H_SYNC,
  parameter int unsigned H_BACK     = VGA_H_BACK,
  parameter int unsigned V_VISIBLE  = VGA_V_VISIBLE,
  parameter int unsigned V_FRONT    = VGA_V_FRONT,
  parameter int unsigned V_SYNC     = VGA_V_SYNC,
  parameter int unsigned V_BACK     = VGA_V_BACK,
  parameter int unsigned SYNC_DELAY = VGA_SYNC_DELAY
) (
  input  logic       clk,
  input  logic       reset,
  output logic       enable,
  output logic [9:0] pixel_counter,
  output logic [8:0] line_counter,
  output logic [1:0] pixel_state,
  output logic       hsync,
  output logic       vsync,
  output logic       frame_start
);

  localparam int unsigned H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS_W  = 10'(H_VISIBLE);
  localparam logic [9:0] V_VIS_W  = 10'(V_VISIBLE);
  localparam logic [9:0] HS_FIRST = 10'(H_VISIBLE + H_FRONT);
  localparam logic [9:0] HS_LAST  = 10'(H_VISIBLE + H_FRONT + H_SYNC - 1);
  localparam logic [9:0] VS_FIRST = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0] VS_LAST  = 10'(V_VISIBLE + V_FRONT + V_SYNC - 1);

  pixel_state_t state_q, state_d;
  logic [9:0]   pixel_q, pixel_d;
  logic [9:0]   v_count_q, v_count_d;
  logic         enable_q, enable_d;
  logic         hsync_raw, vsync_raw;
  logic [1:0]   sync_dly;

  always_comb begin
    state_d   = pixel_state_t'(state_q + 2'd1);
    pixel_d   = pixel_q;
    v_count_d = v_count_q;
    if (state_q == DRAW) begin
      if (pixel_q == H_LAST) begin
        pixel_d   = '0;
        v_count_d = (v_count_q == V_LAST) ? '0 : v_count_q + 10'd1;
      end else begin
        pixel_d = pixel_q + 10'd1;
      end
    end
    // Enable is registered from the next-state counters so it stays flat
    // across all four phases and is glitch-free downstream.
    enable_d = (pixel_d < H_VIS_W) && (v_count_d < V_VIS_W);
  end

  always_comb begin
    hsync_raw = !in_span(pixel_q, HS_FIRST, HS_LAST);
    vsync_raw = !in_span(v_count_q, VS_FIRST, VS_LAST);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= TEXT_FETCH;
      pixel_q   <= '0;
      v_count_q <= '0;
      enable_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      pixel_q   <= pixel_d;
      v_count_q <= v_count_d;
      enable_q  <= enable_d;
    end
  end

  sync_delay #(
    .DEPTH (SYNC_DELAY)
  ) u_sync_delay (
    .clk_i  (clk),
    .rst_ni (reset),
    .d_i    ({vsync_raw, hsync_raw}),
    .q_o    (sync_dly)
  );

  assign enable        = enable_q;
  assign pixel_counter = pixel_q;
  assign line_counter  = v_count_q[8:0];
  assign pixel_state   = state_q;
  assign hsync         = sync_dly[0];
  assign vsync         = sync_dly[1];
  assign frame_start   = reset && (pixel_q == '0) && (v_count_q == '0)
                         && (state_q == TEXT_FETCH);

endmodule
`default_nettype wire

// File: tb/tb_vga_timing_gen.sv
`default_nettype none
// ==========================================================================
// tb_vga_timing_gen : full-size and narrow-line instances against a raster model
// Rev 1.0
// ==========================================================================
module tb_vga_timing_gen;

  localparam longint S_HT    = 16;
  localparam longint S_FRAME = 4 * S_HT * 525;
  localparam longint T_MID   = 4 * (S_HT * 300 + 5) + 2;

  logic clk = 1'b0;
  logic rst_n = 1'b1;

  logic       d_en, d_hs, d_vs, d_fs, s_en, s_hs, s_vs, s_fs;
  logic [9:0] d_pix, s_pix;
  logic [8:0] d_line, s_line;
  logic [1:0] d_st, s_st;

  longint t_q;
  int     n_compared = 0;
  int     n_mismatch = 0;
  bit     chk_en = 1'b0;

  vga_timing_gen u_dflt (
    .clk (clk), .reset (rst_n), .enable (d_en), .pixel_counter (d_pix),
    .line_counter (d_line), .pixel_state (d_st), .hsync (d_hs),
    .vsync (d_vs), .frame_start (d_fs)
  );

  vga_timing_gen #(
    .H_VISIBLE (8), .H_FRONT (2), .H_SYNC (3), .H_BACK (3)
  ) u_small (
    .clk (clk), .reset (rst_n), .enable (s_en), .pixel_counter (s_pix),
    .line_counter (s_line), .pixel_state (s_st), .hsync (s_hs),
    .vsync (s_vs), .frame_start (s_fs)
  );

  always #5 clk = ~clk;

  // Clock edges elapsed since the last reset release.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) t_q <= 0;
    else        t_q <= t_q + 1;
  end

  // Expected {enable, pixel, line, state, hsync, vsync, frame_start}.
  function automatic logic [24:0] model(input longint t, input bit in_rst,
                                        input longint ht, input longint hv,
                                        input longint hf, input longint hsw);
    longint pix, line, p3, l3;
    logic   en, hs, vs, fs;
    if (in_rst) return {1'b0, 10'd0, 9'd0, 2'd0, 1'b1, 1'b1, 1'b0};
    pix = (t / 4) % ht;
    line = (t / (4 * ht)) % 525;
    en = (t >= 1) && (pix < hv) && (line < 480);
    hs = 1'b1;
    vs = 1'b1;
    if (t >= 3) begin
      p3 = ((t - 3) / 4) % ht;
      l3 = ((t - 3) / (4 * ht)) % 525;
      hs = !((p3 >= hv + hf) && (p3 < hv + hf + hsw));
      vs = !((l3 >= 490) && (l3 < 492));
    end
    fs = (t % (4 * ht * 525)) == 0;
    return {en, 10'(pix), 9'(line % 512), 2'(t % 4), hs, vs, fs};
  endfunction

  task automatic check(input string name, input logic [63:0] got,
                       input logic [63:0] exp);
    n_compared++;
    if (got !== exp) begin
      n_mismatch++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0d)", name, got, exp, t_q);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_d_rst"}, {d_en, d_pix, d_line, d_st, d_hs, d_vs, d_fs},
          {1'b0, 10'd0, 9'd0, 2'd0, 1'b1, 1'b1, 1'b0});
    check({tag, "_s_rst"}, {s_en, s_pix, s_line, s_st, s_hs, s_vs, s_fs},
          {1'b0, 10'd0, 9'd0, 2'd0, 1'b1, 1'b1, 1'b0});
  endtask

  always @(negedge clk) begin
    if (chk_en && n_mismatch < 40) begin
      check("dflt_cycle", {d_en, d_pix, d_line, d_st, d_hs, d_vs, d_fs},
            model(t_q, !rst_n, 800, 640, 16, 96));
      check("small_cycle", {s_en, s_pix, s_line, s_st, s_hs, s_vs, s_fs},
            model(t_q, !rst_n, S_HT, 8, 2, 3));
    end
  end

  initial begin
    longint t, found_t;
    longint s_vs_low, s_vs_first, s_en_cnt, s_fs_cnt, d_hs_low, d_hs_first;
    s_vs_low = 0; s_vs_first = -1; s_en_cnt = 0; s_fs_cnt = 0;
    d_hs_low = 0; d_hs_first = -1; t = -1; found_t = -1;

    #1 rst_n = 1'b0;
    #2 check_reset_vals("power_on");
    chk_en = 1'b1;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;

    // Free-run for a random stretch, then reset at a random sub-cycle offset.
    repeat ($urandom_range(20, 400)) @(posedge clk);
    #($urandom_range(1, 3)) rst_n = 1'b0;
    #1 check_reset_vals("rand_async");
    repeat ($urandom_range(1, 3)) @(posedge clk);
    #2 rst_n = 1'b1;
    #1 check("fs_after_release", {d_fs, s_fs}, 2'b11);
    check("en_after_release", d_en, 1'b0);

    for (int k = 0; k < 60000; k++) begin
      @(negedge clk);
      t = t_q;
      if (t == 1) check("t1_state_en", {d_st, d_en, d_pix}, {2'd1, 1'b1, 10'd0});
      if (t == 3) check("t3_state_pix", {d_st, d_pix}, {2'd3, 10'd0});
      if (t == 4) check("t4_pix_advance", {d_st, d_pix}, {2'd0, 10'd1});
      if (t == 3199) check("last_pixel", {d_st, d_pix, d_line}, {2'd3, 10'd799, 9'd0});
      if (t == 3200) check("line_wrap", {d_pix, d_line, d_en}, {10'd0, 9'd1, 1'b1});
      if (t >= 3200 && t < 6400 && !d_hs) begin
        d_hs_low++;
        if (d_hs_first < 0) d_hs_first = t;
      end
      if (t < S_FRAME) begin
        if (!s_vs) begin
          s_vs_low++;
          if (s_vs_first < 0) s_vs_first = t;
        end
        if (s_fs) s_fs_cnt++;
      end
      if (t >= 1 && t <= S_FRAME && s_en) s_en_cnt++;
      if (t == 4 * S_HT * 520 + 1)
        check("alias_line520", {s_line, s_en}, {9'd8, 1'b0});
      if (t == 6400) begin
        check("hsync_low_clocks", d_hs_low, 384);
        check("hsync_first_low", d_hs_first, 5827);
      end
      if (t == S_FRAME) begin
        check("vsync_low_clocks", s_vs_low, 128);
        check("vsync_first_low", s_vs_first, 4 * S_HT * 490 + 3);
        check("fs_per_frame", s_fs_cnt, 1);
        check("enable_per_frame", s_en_cnt, 15360);
        check("frame_wrap", {s_fs, s_pix, s_line}, {1'b1, 10'd0, 9'd0});
      end
      if (t == T_MID) break;
    end
    check("reach_mid_frame", t, T_MID);
    check("mid_frame_pos", {s_st, s_pix, s_line}, {2'd2, 10'd5, 9'd300});

    #2 rst_n = 1'b0;
    #1 check_reset_vals("mid_frame");
    repeat ($urandom_range(1, 4)) @(posedge clk);
    #2 rst_n = 1'b1;
    #1 check("fs_restart", {d_fs, s_fs}, 2'b11);

    for (int k = 0; k < S_FRAME + 100; k++) begin
      @(negedge clk);
      if (t_q > 0 && s_fs) begin
        found_t = t_q;
        break;
      end
    end
    check("fs_period", found_t, S_FRAME);

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatch);
    $finish;
  end

endmodule
`default_nettype wire
